// File: rtl/data_mem_lsu_pkg.sv
// data_mem_lsu_pkg: shared types and constants for the load/store unit.
//   - lsu_state_e : FSM states (IDLE -> BUS -> RESP -> IDLE)
//   - SZ_*        : funct3[1:0] access-size encodings (funct3[2] = unsigned load)
//   - TMO_W       : width of the bus timeout counter
//   - is_misaligned / align_lo : alignment helpers keyed on access size
package data_mem_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_BAD = 2'b11;

    localparam int TMO_W = 8;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        return ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'b00));
    endfunction

    // Natural alignment of the low address bits for the given size.
    function automatic logic [1:0] align_lo(input logic [1:0] sz, input logic [1:0] lo);
        logic [1:0] r;
        r = lo;
        if (sz == SZ_H) r = {lo[1], 1'b0};
        if (sz == SZ_W) r = 2'b00;
        return r;
    endfunction

endpackage

// File: rtl/data_mem_lsu_lane_align.sv
// lsu_lane_align: purely combinational lane logic.
//   funct3, addr_lo : access size/sign and byte offset within the word
//   wdata           : right-aligned store data
//   rdata           : raw 32-bit word read from the bus
//   be, wdata_steer : store byte enables and replicated store data
//   rdata_ext       : selected load lane, sign- or zero-extended
module lsu_lane_align
    import data_mem_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_steer,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sgn;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        sgn      = ~funct3[2];
    end

    always_comb begin
        be          = 4'b1111;
        wdata_steer = wdata;
        rdata_ext   = rdata;
        case (funct3[1:0])
            SZ_B: begin
                be          = 4'b0001 << addr_lo;
                wdata_steer = {4{wdata[7:0]}};
                rdata_ext   = {{24{sgn & byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                be          = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_steer = {2{wdata[15:0]}};
                rdata_ext   = {{16{sgn & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store unit between the memory stage and a ready/valid
// data bus of arbitrary latency.
//   req_*   : one load/store request, accepted on req_valid & req_ready
//   stall   : high while a transaction is in flight (state != IDLE)
//   resp_*  : one-cycle completion with extended load data and error flags
//   bus_*   : word-aligned bus access with byte enables
// Optional macro DATA_MEM_LSU_MISALIGN_TRAP_EN: misaligned accesses are
// answered with resp_misaligned instead of being issued force-aligned.
module data_mem_lsu
    import data_mem_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        resp_misaligned,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    lsu_state_e state, state_nx;

    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic [2:0]       f3_q;
    logic [3:0]       be_q;
    logic             we_q, err_q, mis_q;
    logic [TMO_W-1:0] tmo_cnt;

    logic        accept, req_bad, req_mis, tmo_hit;
    logic [1:0]  req_sz, req_lo;
    logic [2:0]  lane_f3;
    logic [1:0]  lane_lo;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_rdata;

    assign req_sz  = req_funct3[1:0];
    assign req_lo  = align_lo(req_sz, req_addr[1:0]);
    assign accept  = req_valid && (state == ST_IDLE);
    assign req_bad = (req_sz == SZ_BAD);
`ifdef DATA_MEM_LSU_MISALIGN_TRAP_EN
    assign req_mis = is_misaligned(req_sz, req_addr[1:0]);
`else
    assign req_mis = 1'b0;
`endif
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // One lane aligner serves both directions: in IDLE it steers the incoming
    // store, afterwards it extracts the load lane from the captured word.
    assign lane_f3 = (state == ST_IDLE) ? req_funct3 : f3_q;
    assign lane_lo = (state == ST_IDLE) ? req_lo : addr_q[1:0];

    lsu_lane_align u_align (
        .funct3      (lane_f3),
        .addr_lo     (lane_lo),
        .wdata       (req_wdata),
        .rdata       (rdata_q),
        .be          (lane_be),
        .wdata_steer (lane_wdata),
        .rdata_ext   (lane_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; bus_ready on the timeout cycle wins over the timeout.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = (req_bad || req_mis) ? ST_RESP : ST_BUS;
            ST_BUS:  if (bus_ready || tmo_hit) state_nx = ST_RESP;
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Capture and bus-wait datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            f3_q    <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    addr_q  <= {req_addr[31:2], req_lo};
                    f3_q    <= req_funct3;
                    we_q    <= req_write;
                    wdata_q <= lane_wdata;
                    be_q    <= req_write ? lane_be : 4'b1111;
                    err_q   <= req_bad;
                    mis_q   <= req_mis;
                    rdata_q <= '0;
                    tmo_cnt <= '0;
                end
                ST_BUS: begin
                    if (bus_ready)    rdata_q <= bus_rdata;
                    else if (tmo_hit) err_q   <= 1'b1;
                    else              tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs: everything is gated by state so IDLE shows the reset values.
    always_comb begin
        req_ready       = (state == ST_IDLE);
        stall           = (state != ST_IDLE);
        bus_valid       = 1'b0;
        bus_we          = 1'b0;
        bus_be          = 4'b0000;
        bus_addr        = '0;
        bus_wdata       = '0;
        resp_valid      = 1'b0;
        resp_rdata      = '0;
        resp_error      = 1'b0;
        resp_misaligned = 1'b0;
        case (state)
            ST_BUS: begin
                bus_valid = 1'b1;
                bus_we    = we_q;
                bus_be    = be_q;
                bus_addr  = {addr_q[31:2], 2'b00};
                bus_wdata = we_q ? wdata_q : '0;
            end
            ST_RESP: begin
                resp_valid      = 1'b1;
                resp_error      = err_q;
                resp_misaligned = mis_q;
                resp_rdata      = (we_q || err_q || mis_q) ? '0 : lane_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store unit between the pipeline's memory stage and the external data memory bus. It accepts one load or store per request, encodes RISC-V size and sign (funct3) into word-aligned bus accesses with byte enables, and waits on a ready/valid bus of arbitrary latency. It returns sign- or zero-extended load data and holds a stall to the pipeline while a transaction is outstanding.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles in BUS before the access is abandoned with an error (≥1, fits 8 bits).
- `clk` in 1: the single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: memory-stage access request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); stores use bits [1:0] only.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_ready` out 1: high only in IDLE; a request is accepted when `req_valid & req_ready`.
- `stall` out 1: high whenever state ≠ IDLE.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_error` out 1: timeout or illegal size, valid with `resp_valid`.
- `resp_misaligned` out 1: misaligned access, valid with `resp_valid`.
- `bus_valid`, `bus_we` out 1; `bus_be` out 4; `bus_addr`, `bus_wdata` out 32; `bus_ready` in 1; `bus_rdata` in 32.

## Operation
- FSM states: IDLE → BUS → RESP → IDLE.
- IDLE: on an accepted request, capture address, funct3, write flag and steered data. Go to RESP with `resp_error=1` if size bits = 11. Go to RESP with `resp_misaligned=1` if the access is misaligned and the macro is defined. Otherwise go to BUS.
- BUS: `bus_valid=1`; all bus outputs are held stable until `bus_ready`. On `bus_ready`, capture `bus_rdata` and go to RESP. If the timeout counter reaches TIMEOUT_CYCLES first, drop `bus_valid`, set `resp_error`, and go to RESP.
- RESP: `resp_valid=1` for exactly one cycle, then IDLE.
- `bus_addr` = {addr[31:2], 2'b00}.
- Store steering:
  - B: `bus_be` = 0001 << addr[1:0]; `bus_wdata` = {4{wdata[7:0]}}.
  - H: `bus_be` = 0011 << {addr[1],1'b0}; `bus_wdata` = {2{wdata[15:0]}}.
  - W: `bus_be` = 1111.
- Loads use `bus_be` = 1111. The lane is selected by the captured addr[1:0] (halfword by addr[1]), then sign-extended (B, H) or zero-extended (BU, HU).
- Misaligned means H with addr[0]=1, or W with addr[1:0]≠0.
- Reset values: state IDLE; `req_ready=1`; every other output 0, including all bus outputs, `resp_*` and `stall`. Timeout counter is 0.
- Reset mid-transaction: the FSM returns to IDLE on that edge and `bus_valid` falls. No response is produced and any late `bus_ready` is ignored.
- A `bus_ready` arriving in IDLE or RESP is ignored.

## Timing
- Request accepted at edge E0. `bus_valid` is high in the cycle after E0.
- If `bus_ready` is sampled at edge Ek, `resp_valid` is high in the cycle after Ek. Minimum latency: `resp_valid` two cycles after the accept cycle.
- Error and misaligned responses skip BUS: `resp_valid` in the cycle after E0.
- The timeout counter is cleared on BUS entry and increments every BUS cycle without `bus_ready`. With TIMEOUT_CYCLES=N, the error response follows N BUS cycles.
- `bus_ready` coinciding with the timeout edge counts as success.
- Back-to-back requests: the next accept is possible in the cycle after RESP.

## Configuration
- `DATA_MEM_LSU_MISALIGN_TRAP_EN` defined: misaligned accesses never reach the bus and respond with `resp_misaligned=1`.
- Undefined: misaligned accesses are issued with the low address bits forced to natural alignment (H clears bit 0, W clears bits [1:0]), and `resp_misaligned` is tied to 0.

## Structure
- Package `data_mem_lsu_pkg`: FSM state enum, funct3 size/sign constants, and the timeout counter width.
- One combinational sub-module, `lsu_lane_align`: store byte-enable/data steering and load lane extract/extend. Shared by the capture and response paths.

## Test plan
- SB, addr 0x1003, wdata 0xAB, `bus_ready` immediate → `bus_addr`=0x1000, `bus_be`=1000, `bus_wdata`=0xABABABAB, `resp_valid` 2 cycles after accept, `resp_rdata`=0.
- LB vs LBU, addr 0x2001, `bus_rdata`=0x0000F000 → LB returns 0xFFFFFFF0; LBU returns 0x000000F0.
- LH, addr 0x2002, `bus_ready` after 5 cycles, `bus_rdata`=0x8001_0000 → `bus_*` stable for 5 cycles, `stall` high throughout, `resp_rdata`=0xFFFF8001.
- TIMEOUT_CYCLES=4, `bus_ready` never asserted → `bus_valid` drops after 4 BUS cycles, `resp_error=1`, `resp_rdata=0`, returns to IDLE.
- LW, addr 0x3002:
  - Macro defined: no `bus_valid`, `resp_misaligned=1` the cycle after accept.
  - Macro undefined: `bus_addr`=0x3000, normal response.
- `reset` asserted during BUS, then `bus_ready` pulsed → no `resp_valid`; all outputs at reset values the next cycle; `req_ready=1`.
